heat_sweep_sched: RTL

//  Control and scheduling block for the 5x5 heat-diffusion stencil datapath.
//  It owns the single host command port (write/read/config) and the grid memory address port.
//  It sequences full-grid sweeps one cell per clock, so one iteration takes GRID_W*GRID_H cycles.
//  It ping-pongs the source/destination bank per iteration and arbitrates host commands

---
 rtl/heat_pkg.sv | 12 +
 rtl/heat_cell_walker.sv | 34 +++
 rtl/heat_sweep_sched.sv | 93 +++++++++
 3 files changed

// File: rtl/heat_pkg.sv
// heat_pkg: shared constants, op codes and scheduler states for the heat-diffusion stencil
package heat_pkg;
  localparam int GRID_W    = 5;
  localparam int GRID_H    = 5;
  localparam int CELLS     = GRID_W * GRID_H;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 4;
  localparam int ALPHA_W   = 3;
  localparam int ALPHA_MAX = 4;
  typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_READ, OP_CONFIG} op_t;
  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_RSP, SWEEP} state_t;
endpackage

// File: rtl/heat_cell_walker.sv
// heat_cell_walker: row-major cell walker with edge flags, shared by the sweep and scan paths
module heat_cell_walker #(
  parameter int GRID_W = heat_pkg::GRID_W,
  parameter int GRID_H = heat_pkg::GRID_H,
  parameter int ADDR_W = heat_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic [3:0]        edge_flags,
  output logic              last
);
  localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] MAX_R = ADDR_W'(GRID_H - 1);
  logic col_end;
  assign col_end    = col == MAX_C;
  assign last       = col_end && row == MAX_R;
  assign edge_flags = {row == '0, row == MAX_R, col == '0, col_end};
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      index <= '0;
      row   <= '0;
      col   <= '0;
    end else if (advance) begin
      index <= last ? '0 : index + 1'b1;
      col   <= col_end ? '0 : col + 1'b1;
      row   <= last ? '0 : col_end ? row + 1'b1 : row;
    end
  end
endmodule

// File: rtl/heat_sweep_sched.sv
// heat_sweep_sched: host command port, sweep sequencing and bank ping-pong for the stencil datapath
module heat_sweep_sched
  import heat_pkg::*;
#(
  parameter int GRID_W    = heat_pkg::GRID_W,
  parameter int GRID_H    = heat_pkg::GRID_H,
  parameter int ADDR_W    = heat_pkg::ADDR_W,
  parameter int DATA_W    = heat_pkg::DATA_W,
  parameter int ALPHA_W   = heat_pkg::ALPHA_W,
  parameter int ALPHA_MAX = heat_pkg::ALPHA_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [7:0]         cmd_data,
  input  logic               run_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               src_bank,
  output logic               step_valid,
  output logic [ADDR_W-1:0]  step_addr,
  output logic [3:0]         step_edge,
  output logic               step_last,
  output logic [ALPHA_W-1:0] alpha,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic [7:0]         iter_count,
  output logic               busy
);
  localparam logic [ALPHA_W-1:0] A_MAX = ALPHA_W'(ALPHA_MAX);
  state_t             state, nxt;
  logic [ADDR_W-1:0]  addr_q, idx;
  logic [DATA_W-1:0]  data_q;
  logic [3:0]         edges;
  logic               last, in_range, accept;
  logic [ALPHA_W-1:0] alpha_in;
  heat_cell_walker #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_walker (
    .clk(clk), .rst(rst), .clear(!step_valid), .advance(step_valid),
    .index(idx), .row(), .col(), .edge_flags(edges), .last(last)
  );
  assign cmd_ready  = state == IDLE;
  assign busy       = !cmd_ready;
  assign accept     = cmd_valid && cmd_ready;
  assign step_valid = state == SWEEP;
  assign in_range   = addr_q < ADDR_W'(GRID_W * GRID_H);
  assign alpha_in   = cmd_data[ALPHA_W-1:0];
  assign mem_we     = state == WRITE && in_range;
  assign mem_addr   = step_valid ? idx : (state == WRITE || state == READ) ? addr_q : '0;
  assign mem_wdata  = state == WRITE ? data_q : '0;
  assign rd_valid   = state == READ_RSP;
  assign rd_data    = rd_valid && in_range ? mem_rdata : '0;
  assign step_addr  = step_valid ? idx : '0;
  assign step_edge  = step_valid ? edges : '0;
  assign step_last  = step_valid && last;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = cmd_valid ? (cmd_op == OP_WRITE ? WRITE : cmd_op == OP_READ ? READ : IDLE)
                                : run_en ? SWEEP : IDLE;
      WRITE:    nxt = IDLE;
      READ:     nxt = READ_RSP;
      READ_RSP: nxt = IDLE;
      SWEEP:    nxt = !last ? SWEEP : (run_en && !cmd_valid) ? SWEEP : IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      alpha      <= ALPHA_W'(1);
      src_bank   <= 1'b0;
      iter_count <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data[DATA_W-1:0];
        if (cmd_op == OP_CONFIG) alpha <= alpha_in > A_MAX ? A_MAX : alpha_in;
      end
      if (step_valid && last) begin
        src_bank   <= ~src_bank;
        iter_count <= iter_count + 8'd1;
      end
    end
  end
endmodule
